// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered channel mux with fixed-select and round-robin modes.
module mux_rr_reg #(
  parameter int SIZE  = 32,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CH*SIZE-1:0]   data_i,
  input  logic [CH-1:0]        valid_i,
  input  logic [SEL_W-1:0]     select_i,
  input  logic                 mode_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic [SIZE-1:0]      data_o,
  output logic                 valid_o,
  output logic [CH-1:0]        grant_o,
  output logic [SEL_W-1:0]     sel_o
);
  localparam int N = 2**SEL_W;
  logic [SIZE-1:0]  w_ch [N];
  logic [N-1:0]     w_vp;
  logic             w_rr_hit;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W-1:0] w_j;
  logic [CH-1:0]    w_fix_oh;
  logic [CH-1:0]    w_rr_oh;
  logic [SIZE-1:0]  r_data;
  logic             r_valid;
  logic [CH-1:0]    r_grant;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  // Pad to the full select range so out-of-range indices read zero data and no request.
  genvar k;
  for (k = 0; k < N; k++) begin : g_ch
    if (k < CH) begin : g_on
      assign w_ch[k] = data_i[k*SIZE +: SIZE];
      assign w_vp[k] = valid_i[k];
    end else begin : g_off
      assign w_ch[k] = '0;
      assign w_vp[k] = 1'b0;
    end
  end
  // Scan farthest-to-nearest so the nearest requester after ptr wins; wrap is modulo CH.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = r_ptr;
    w_j      = '0;
    for (int i = CH; i >= 1; i--) begin
      w_j = SEL_W'((int'(r_ptr) + i) % CH);
      if (w_vp[w_j]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_j;
      end
    end
  end
  assign w_fix_oh = CH'(1) << select_i;
  assign w_rr_oh  = CH'(1) << w_rr_idx;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(CH-1);
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_grant <= '0;
    end else if (!stall_i) begin
      if (!mode_i) begin
        r_data  <= w_ch[select_i];
        r_sel   <= select_i;
        r_valid <= w_vp[select_i];
        r_grant <= w_vp[select_i] ? w_fix_oh : '0;
      end else if (w_rr_hit) begin
        r_data  <= w_ch[w_rr_idx];
        r_sel   <= w_rr_idx;
        r_valid <= 1'b1;
        r_grant <= w_rr_oh;
        r_ptr   <= w_rr_idx;
      end else begin
        r_valid <= 1'b0;
        r_grant <= '0;
      end
    end
  end
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign grant_o = r_grant;
  assign sel_o   = r_sel;
endmodule
